// File: rtl/edge_loader.sv
// Edge-table writer: packs (src, dst) edge pairs into ping-pong edge RAM banks and
// publishes each closed bank to the scheduler. `task` is a reserved word, so that port is task_pending.
module edge_loader #(
  parameter int unsigned NODE_W = 12,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NODE_W-1:0]     s_src,
  input  logic [NODE_W-1:0]     s_dst,
  input  logic                  s_last,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [2*NODE_W-1:0]   wr_data,
  output logic [1:0]            bank_valid,
  output logic [ADDR_W:0]       bank_count0,
  output logic [ADDR_W:0]       bank_count1,
  output logic [1:0]            bank_last,
  input  logic [1:0]            bank_release,
  output logic                  task_pending
);

  typedef enum logic [1:0] {FILL, CLOSE, WAIT} state_t;

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  state_t          state;
  logic            fill_bank;
  logic [ADDR_W:0] wr_ptr;
  logic            close_last;

  logic            accept;
  logic            closing;
  logic            other_bank;
  logic [1:0]      freed;

  assign accept       = s_valid & s_ready;
  assign closing      = accept & ((wr_ptr == LAST_PTR) | s_last);
  assign other_bank   = ~fill_bank;
  assign freed        = bank_valid & bank_release;
  assign task_pending = |bank_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      fill_bank   <= 1'b0;
      wr_ptr      <= '0;
      close_last  <= 1'b0;
      s_ready     <= 1'b0;
      wr_en       <= 1'b0;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      bank_valid  <= '0;
      bank_count0 <= '0;
      bank_count1 <= '0;
      bank_last   <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_bank <= fill_bank;
        wr_addr <= wr_ptr[ADDR_W-1:0];
        wr_data <= {s_dst, s_src};
        wr_ptr  <= wr_ptr + PTR_ONE;
      end

      // Releases of non-valid banks are masked out by freed
      if (freed[0]) begin
        bank_valid[0] <= 1'b0;
        bank_last[0]  <= 1'b0;
        bank_count0   <= '0;
      end
      if (freed[1]) begin
        bank_valid[1] <= 1'b0;
        bank_last[1]  <= 1'b0;
        bank_count1   <= '0;
      end

      unique case (state)
        FILL: begin
          if (closing) begin
            state      <= CLOSE;
            s_ready    <= 1'b0;
            close_last <= s_last;
          end else begin
            s_ready <= 1'b1;
          end
        end
        CLOSE: begin
          // wr_ptr already counts the closing edge, so it is the entry count
          bank_valid[fill_bank] <= 1'b1;
          bank_last[fill_bank]  <= close_last;
          if (fill_bank) bank_count1 <= wr_ptr;
          else           bank_count0 <= wr_ptr;
          fill_bank <= other_bank;
          wr_ptr    <= '0;
          if (bank_valid[other_bank] && !bank_release[other_bank]) begin
            state   <= WAIT;
            s_ready <= 1'b0;
          end else begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (bank_release[fill_bank]) begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= FILL;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_loader.sv
// Directed bench for edge_loader: bank-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_edge_loader;

  localparam int NODE_W = 12;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [NODE_W-1:0]   s_src = '0;
  logic [NODE_W-1:0]   s_dst = '0;
  logic                s_last = 1'b0;
  logic                wr_en;
  logic                wr_bank;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*NODE_W-1:0] wr_data;
  logic [1:0]          bank_valid;
  logic [ADDR_W:0]     bank_count0;
  logic [ADDR_W:0]     bank_count1;
  logic [1:0]          bank_last;
  logic [1:0]          bank_release = '0;
  logic                task_pending;

  edge_loader #(.NODE_W(NODE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_src(s_src), .s_dst(s_dst), .s_last(s_last),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .bank_valid(bank_valid), .bank_count0(bank_count0), .bank_count1(bank_count1),
    .bank_last(bank_last), .bank_release(bank_release), .task_pending(task_pending)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  // Reference model: what each bank holds and where the next edge lands
  bit [1:0]            m_valid = '0;
  bit [1:0]            m_last  = '0;
  int                  m_count [2];
  int                  m_fill = 0;
  int                  m_ptr = 0;
  bit                  m_close_pending = 1'b0;
  bit                  m_close_last = 1'b0;
  bit                  m_after_reset = 1'b1;
  bit                  m_acc = 1'b0;
  bit                  m_wr_en = 1'b0;
  int                  m_wr_bank = 0;
  int                  m_wr_addr = 0;
  logic [2*NODE_W-1:0] m_wr_data = '0;

  function automatic bit model_ready();
    return !m_after_reset && !m_close_pending && !m_valid[m_fill];
  endfunction

  task automatic model_step();
    bit rdy;
    bit close_now;
    bit cl_last;
    if (rst) begin
      m_valid = '0; m_last = '0; m_count[0] = 0; m_count[1] = 0;
      m_fill = 0; m_ptr = 0; m_close_pending = 1'b0; m_close_last = 1'b0;
      m_after_reset = 1'b1; m_acc = 1'b0; m_wr_en = 1'b0;
      m_wr_bank = 0; m_wr_addr = 0; m_wr_data = '0;
    end else begin
      rdy = model_ready();
      m_acc = s_valid && rdy;
      m_wr_en = m_acc;
      close_now = 1'b0;
      cl_last = 1'b0;
      if (m_acc) begin
        m_wr_bank = m_fill;
        m_wr_addr = m_ptr;
        m_wr_data = {s_dst, s_src};
        close_now = (m_ptr + 1 == DEPTH) || s_last;
        cl_last = s_last;
        m_ptr++;
      end
      for (int b = 0; b < 2; b++) begin
        if (bank_release[b] && m_valid[b]) begin
          m_valid[b] = 1'b0; m_last[b] = 1'b0; m_count[b] = 0;
        end
      end
      if (m_close_pending) begin
        m_valid[m_fill] = 1'b1;
        m_count[m_fill] = m_ptr;
        m_last[m_fill]  = m_close_last;
        m_fill = 1 - m_fill;
        m_ptr = 0;
        m_close_pending = 1'b0;
      end
      if (close_now) begin
        m_close_pending = 1'b1;
        m_close_last = cl_last;
      end
      m_after_reset = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("s_ready", 32'(s_ready), 32'(model_ready()));
      chk("wr_en", 32'(wr_en), 32'(m_wr_en));
      if (m_wr_en) begin
        chk("wr_bank", 32'(wr_bank), 32'(m_wr_bank));
        chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
        chk("wr_data", 32'(wr_data), 32'(m_wr_data));
      end
      chk("bank_valid", 32'(bank_valid), 32'(m_valid));
      chk("bank_count0", 32'(bank_count0), 32'(m_count[0]));
      chk("bank_count1", 32'(bank_count1), 32'(m_count[1]));
      chk("bank_last", 32'(bank_last), 32'(m_last));
      chk("task", 32'(task_pending), 32'(m_valid != 2'b00));
    end
  end

  task automatic send_edge(input logic [NODE_W-1:0] src, input logic [NODE_W-1:0] dst,
                           input logic last);
    s_valid = 1'b1; s_src = src; s_dst = dst; s_last = last;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (m_acc) begin
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    n_total++;
    $display("FAIL accept_timeout: edge src=0x%0h not accepted within 200 cycles", src);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_release(input logic [1:0] mask);
    bank_release = mask;
    tick();
    bank_release = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_bank_valid"}, 32'(bank_valid), 32'd0);
    chk({tag, "_count0"}, 32'(bank_count0), 32'd0);
    chk({tag, "_count1"}, 32'(bank_count1), 32'd0);
    chk({tag, "_last"}, 32'(bank_last), 32'd0);
    chk({tag, "_task"}, 32'(task_pending), 32'd0);
  endtask

  task automatic send_run(input int n, input int base, input bit last_on_final);
    for (int i = 0; i < n; i++)
      send_edge(12'(base + i), 12'(12'h800 | (base + i)), last_on_final && (i == n - 1));
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk_on = 1'b1;
    chk_reset_state("rst");
    rst = 1'b0;
    tick();
    chk("rst_release_ready", 32'(s_ready), 32'd1);

    // Single edge with s_last
    send_edge(12'h003, 12'h00A, 1'b1);
    chk("single_wr_en", 32'(wr_en), 32'd1);
    chk("single_wr_data", 32'(wr_data), 32'h00A003);
    chk("single_wr_addr", 32'(wr_addr), 32'd0);
    chk("single_wr_bank", 32'(wr_bank), 32'd0);
    chk("single_close_ready", 32'(s_ready), 32'd0);
    tick();
    chk("single_valid", 32'(bank_valid), 32'b01);
    chk("single_count0", 32'(bank_count0), 32'd1);
    chk("single_last", 32'(bank_last), 32'b01);
    chk("single_task", 32'(task_pending), 32'd1);
    pulse_release(2'b01);
    chk("single_released", 32'(bank_valid), 32'b00);

    // Full bank, then fill bank 1, then back-pressure
    do_reset();
    send_run(32, 0, 1'b0);
    chk("full_last_addr", 32'(wr_addr), 32'd31);
    chk("full_close_ready", 32'(s_ready), 32'd0);
    send_edge(12'h100, 12'h200, 1'b0);
    chk("full_count0", 32'(bank_count0), 32'd32);
    chk("full_valid", 32'(bank_valid), 32'b01);
    chk("full_next_bank", 32'(wr_bank), 32'd1);
    chk("full_next_addr", 32'(wr_addr), 32'd0);
    send_run(31, 1, 1'b0);
    s_valid = 1'b1; s_src = 12'h555; s_dst = 12'hAAA; s_last = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("bp_ready", 32'(s_ready), 32'd0);
    chk("bp_no_write", 32'(wr_en), 32'd0);
    chk("bp_valid", 32'(bank_valid), 32'b11);
    chk("bp_count1", 32'(bank_count1), 32'd32);
    pulse_release(2'b01);
    chk("bp_ready_after_release", 32'(s_ready), 32'd1);
    chk("bp_still_no_write", 32'(wr_en), 32'd0);
    send_edge(12'h555, 12'hAAA, 1'b0);
    chk("bp_wr_bank", 32'(wr_bank), 32'd0);
    chk("bp_wr_addr", 32'(wr_addr), 32'd0);
    chk("bp_wr_data", 32'(wr_data), 32'hAAA555);

    // 33-edge task, release of bank 0 during bank 1's close cycle
    do_reset();
    send_run(33, 16, 1'b1);
    chk("t33_count0", 32'(bank_count0), 32'd32);
    chk("t33_last0", 32'(bank_last), 32'b00);
    pulse_release(2'b01);
    chk("t33_valid", 32'(bank_valid), 32'b10);
    chk("t33_count1", 32'(bank_count1), 32'd1);
    chk("t33_last", 32'(bank_last), 32'b10);
    chk("t33_ready", 32'(s_ready), 32'd1);
    send_edge(12'h7FF, 12'hFFF, 1'b0);
    chk("t33_next_bank", 32'(wr_bank), 32'd0);
    chk("t33_next_addr", 32'(wr_addr), 32'd0);
    chk("t33_next_data", 32'(wr_data), 32'hFFF7FF);

    // Spurious and dual release
    do_reset();
    pulse_release(2'b10);
    chk("spur_valid", 32'(bank_valid), 32'b00);
    chk("spur_ready", 32'(s_ready), 32'd1);
    send_run(33, 64, 1'b1);
    tick();
    chk("dual_pre_valid", 32'(bank_valid), 32'b11);
    chk("dual_pre_ready", 32'(s_ready), 32'd0);
    pulse_release(2'b11);
    chk("dual_valid", 32'(bank_valid), 32'b00);
    chk("dual_task", 32'(task_pending), 32'd0);
    chk("dual_ready", 32'(s_ready), 32'd1);

    // Reset mid-fill
    do_reset();
    send_run(10, 200, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("midrst");
    tick();
    send_edge(12'h0AB, 12'h0CD, 1'b0);
    chk("midrst_bank", 32'(wr_bank), 32'd0);
    chk("midrst_addr", 32'(wr_addr), 32'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
